capture_trigger_ctrl: RTL and testbench
=======================================

// Module: capture_trigger_ctrl
//
// PURPOSE
//   Acquisition trigger controller. It sits directly downstream of the edge
//   trigger stage and consumes its one-cycle trigger pulse.
//   Once software arms it, the block waits for a trigger pulse. It then opens
//   a capture window lasting exactly N sample strobes and reports completion.
//   capture_en qualifies samples into the sample buffer/FIFO.
//
// PARAMETERS
//   CNT_WIDTH   16  Width of the post-trigger sample count and of sample_idx.
//   AUTO_REARM  0   1: DONE returns to ARMED. 0: DONE returns to IDLE.
//
// PORTS
//   clk           in   1          System clock. All logic is on posedge.
//   reset         in   1          Synchronous, active-high reset.
//   arm           in   1          Arm request (level or pulse). Honoured only in IDLE.
//   abort         in   1          Cancel. Returns to IDLE from any state.
//   trig_pulse    in   1          One-cycle trigger pulse from the edge trigger.
//   sample_stb    in   1          One-cycle sample-rate strobe.
//   post_samples  in   CNT_WIDTH  Capture length N. Latched when arm is accepted.
//   armed         out  1          High while in ARMED.
//   capture_en    out  1          High while in CAPTURE. Qualifies sample_stb.
//   trig_seen     out  1          One-cycle pulse on the cycle ARMED exits on trigger.
//   done          out  1          One-cycle pulse while in DONE.
//   sample_idx    out  CNT_WIDTH  Index of the next sample to capture, 0..N-1.
//
// BEHAVIOUR
//   - All outputs are registered or decoded from the state register; there
//     are no combinational paths from inputs to outputs.
//   - Reset: state=IDLE; armed=0, capture_en=0, trig_seen=0, done=0,
//     sample_idx=0; latched length len=0.
//   - States: IDLE, ARMED, CAPTURE, DONE.
//   - IDLE:
//       arm=1 -> ARMED next cycle; len <= post_samples.
//       trig_pulse and sample_stb are ignored.
//   - ARMED:
//       trig_pulse=1 and len!=0 -> CAPTURE; sample_idx <= 0; trig_seen=1
//         for the one cycle CAPTURE is entered.
//       trig_pulse=1 and len==0 -> DONE; trig_seen=1 in the same cycle.
//       arm is ignored.
//   - CAPTURE:
//       Each sample_stb increments sample_idx.
//       sample_stb with sample_idx==len-1 -> DONE; sample_idx <= len.
//       Exactly len strobes are seen with capture_en=1.
//       A sample_stb on the trigger cycle itself is not captured (latency 1).
//       Further trig_pulse is ignored; there is no retrigger.
//   - DONE: lasts one cycle, done=1. Next state is IDLE (AUTO_REARM=0) or
//     ARMED (AUTO_REARM=1). On re-arm, len keeps its latched value.
//   - Priority, highest first: reset > abort > all other transitions.
//       abort in any state -> IDLE next cycle.
//       abort in CAPTURE: done is never asserted and sample_idx holds its
//         value.
//       abort and arm in the same cycle -> IDLE.
//   - Simultaneous events:
//       arm and trig_pulse together in IDLE: arm only. The trigger is lost,
//         because armed takes effect next cycle.
//       trig_pulse and sample_stb together in ARMED: enter CAPTURE, but do not
//         count the strobe.
//   - sample_idx holds its value through DONE and IDLE until the next capture
//     start.
//   - Wrap-around: the counter never wraps. The maximum N is 2**CNT_WIDTH-1;
//     compare against len-1 only when len!=0.
//   - Reset mid-capture returns all outputs to their reset values on the
//     next edge.
//
// TESTING
//   1. arm with post_samples=4; trig_pulse 5 cycles later; sample_stb every
//      3rd cycle -> trig_seen 1 cycle; capture_en high for exactly 4 strobes;
//      sample_idx 0,1,2,3 then 4; done single pulse; back to IDLE.
//   2. post_samples=0: arm, then trig -> trig_seen and DONE on the same cycle;
//      capture_en never high; done single pulse.
//   3. trig_pulse in IDLE, then arm+trig in the same cycle -> state stays
//      IDLE/ARMED with no trig_seen; a later trig starts capture.
//   4. abort after 2 of 8 samples -> IDLE next cycle; done=0; sample_idx=2;
//      a further arm+trig runs a full 8-sample capture.
//   5. AUTO_REARM=1, N=2, three trig pulses spaced beyond the window -> three
//      done pulses, armed=1 between captures; a trig during CAPTURE is ignored.
//   6. reset asserted mid-capture (sample_idx=5) -> all outputs 0 on the next
//      edge; arm ignored while reset=1.

Source files
------------

// File: rtl/capture_trigger_ctrl_if.sv
// Control/status bundle between software-side control logic, the edge
// trigger stage and the acquisition trigger controller.
interface capture_trigger_ctrl_if #(
  parameter int CNT_WIDTH = 16
) ();
  logic                 arm;
  logic                 abort;
  logic                 trig_pulse;
  logic                 sample_stb;
  logic [CNT_WIDTH-1:0] post_samples;
  logic                 armed;
  logic                 capture_en;
  logic                 trig_seen;
  logic                 done;
  logic [CNT_WIDTH-1:0] sample_idx;

  // Drives requests and observes status.
  modport master (
    output arm, abort, trig_pulse, sample_stb, post_samples,
    input  armed, capture_en, trig_seen, done, sample_idx
  );

  // The trigger controller itself.
  modport slave (
    input  arm, abort, trig_pulse, sample_stb, post_samples,
    output armed, capture_en, trig_seen, done, sample_idx
  );
endinterface

// File: rtl/capture_trigger_ctrl.sv
// Acquisition trigger controller: once armed, waits for a trigger pulse,
// then opens a capture window of exactly N sample strobes and signals done.
module capture_trigger_ctrl #(
  parameter int CNT_WIDTH  = 16,
  parameter bit AUTO_REARM = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  capture_trigger_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] idx_q, idx_d;
  logic                 trig_seen_q, trig_seen_d;

  // State, latched length, sample index and trigger flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      idx_q       <= '0;
      trig_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      trig_seen_q <= trig_seen_d;
    end
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    trig_seen_d = 1'b0;
    if (bus.abort) begin
      // sample_idx deliberately holds so software can see how far it got.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.arm) begin
            state_d = ARMED;
            len_d   = bus.post_samples;
          end
        end
        ARMED: begin
          // A strobe coinciding with the trigger is not counted.
          if (bus.trig_pulse) begin
            trig_seen_d = 1'b1;
            if (len_q != '0) begin
              state_d = CAPTURE;
              idx_d   = '0;
            end else begin
              state_d = DONE;
            end
          end
        end
        CAPTURE: begin
          // len_q is non-zero here, so len_q-1 cannot underflow and the
          // index stops at len_q without wrapping.
          if (bus.sample_stb) begin
            idx_d = idx_q + ONE;
            if (idx_q == len_q - ONE) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          state_d = AUTO_REARM ? ARMED : IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.armed      = (state_q == ARMED);
  assign bus.capture_en = (state_q == CAPTURE);
  assign bus.done       = (state_q == DONE);
  assign bus.trig_seen  = trig_seen_q;
  assign bus.sample_idx = idx_q;

endmodule

// File: tb/tb_capture_trigger_ctrl.sv
// Bench for capture_trigger_ctrl: a directed vector table on a one-shot
// instance, plus hand-written auto-rearm and max-length sequences.
module tb_capture_trigger_ctrl;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  capture_trigger_ctrl_if #(.CNT_WIDTH(16)) if0 ();
  capture_trigger_ctrl_if #(.CNT_WIDTH(4))  if1 ();

  capture_trigger_ctrl #(.CNT_WIDTH(16), .AUTO_REARM(1'b0)) u0 (
    .clk(clk), .reset(rst0), .bus(if0.slave)
  );
  capture_trigger_ctrl #(.CNT_WIDTH(4), .AUTO_REARM(1'b1)) u1 (
    .clk(clk), .reset(rst1), .bus(if1.slave)
  );

  // Expected output code: {armed, capture_en, trig_seen, done}
  localparam logic [3:0] O_IDLE  = 4'b0000;
  localparam logic [3:0] O_ARM   = 4'b1000;
  localparam logic [3:0] O_CAP   = 4'b0100;
  localparam logic [3:0] O_CAPT  = 4'b0110;
  localparam logic [3:0] O_DONE  = 4'b0001;
  localparam logic [3:0] O_DONET = 4'b0011;

  typedef struct {
    logic        r, a, ab, t, s;
    logic [15:0] ps;
    logic [3:0]  eo;
    logic [15:0] ei;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic a, logic ab, logic t, logic s,
                              logic [15:0] ps, logic [3:0] eo, logic [15:0] ei);
    vec_t v;
    v.r = r; v.a = a; v.ab = ab; v.t = t; v.s = s;
    v.ps = ps; v.eo = eo; v.ei = ei;
    vecs.push_back(v);
  endfunction

  task automatic step1(logic r, logic a, logic ab, logic t, logic s, logic [3:0] ps);
    @(negedge clk);
    rst1 = r; if1.arm = a; if1.abort = ab; if1.trig_pulse = t;
    if1.sample_stb = s; if1.post_samples = ps;
    @(posedge clk);
    #1;
    done_cnt += int'(if1.done);
  endtask

  task automatic chk1(string name, logic [3:0] eo, logic [3:0] ei);
    logic [3:0] ao;
    ao = {if1.armed, if1.capture_en, if1.trig_seen, if1.done};
    checks++;
    if (ao !== eo || if1.sample_idx !== ei) begin
      errors++;
      $display("FAIL %s: got outs=%b idx=%0d, required outs=%b idx=%0d",
               name, ao, if1.sample_idx, eo, ei);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    if0.arm = 0; if0.abort = 0; if0.trig_pulse = 0; if0.sample_stb = 0; if0.post_samples = '0;
    if1.arm = 0; if1.abort = 0; if1.trig_pulse = 0; if1.sample_stb = 0; if1.post_samples = '0;

    // reset state
    add(1, 0, 0, 0, 0, 16'd0, O_IDLE, 16'd0);
    // 1: N=4, trigger 5 cycles after arm, strobe every 3rd cycle
    add(0, 1, 0, 0, 0, 16'd4, O_ARM, 16'd0);
    for (int k = 0; k < 4; k++) add(0, 0, 0, 0, 0, 16'd0, O_ARM, 16'd0);
    add(0, 0, 0, 1, 0, 16'd0, O_CAPT, 16'd0);
    for (int k = 0; k < 4; k++) begin
      add(0, 0, 0, 0, 0, 16'd0, O_CAP, 16'(k));
      add(0, 0, 0, 0, 0, 16'd0, O_CAP, 16'(k));
      if (k < 3) add(0, 0, 0, 0, 1, 16'd0, O_CAP, 16'(k + 1));
      else       add(0, 0, 0, 0, 1, 16'd0, O_DONE, 16'd4);
    end
    add(0, 0, 0, 0, 0, 16'd0, O_IDLE, 16'd4);
    // 2: N=0 -> trig_seen and done together
    add(0, 1, 0, 0, 0, 16'd0, O_ARM, 16'd4);
    add(0, 0, 0, 1, 0, 16'd0, O_DONET, 16'd4);
    add(0, 0, 0, 0, 0, 16'd0, O_IDLE, 16'd4);
    // 3: trigger in IDLE, arm+trig together, trig+strobe together
    add(0, 0, 0, 1, 0, 16'd0, O_IDLE, 16'd4);
    add(0, 1, 0, 1, 0, 16'd3, O_ARM, 16'd4);
    add(0, 0, 0, 1, 1, 16'd0, O_CAPT, 16'd0);
    add(0, 0, 0, 0, 1, 16'd0, O_CAP, 16'd1);
    add(0, 0, 0, 0, 1, 16'd0, O_CAP, 16'd2);
    add(0, 0, 0, 0, 1, 16'd0, O_DONE, 16'd3);
    add(0, 0, 0, 0, 0, 16'd0, O_IDLE, 16'd3);
    // 4: abort after 2 of 8, arm+abort, abort in ARMED, full 8-sample run
    add(0, 1, 0, 0, 0, 16'd8, O_ARM, 16'd3);
    add(0, 0, 0, 1, 0, 16'd0, O_CAPT, 16'd0);
    add(0, 0, 0, 0, 1, 16'd0, O_CAP, 16'd1);
    add(0, 0, 0, 0, 1, 16'd0, O_CAP, 16'd2);
    add(0, 0, 1, 0, 1, 16'd0, O_IDLE, 16'd2);
    add(0, 0, 0, 0, 0, 16'd0, O_IDLE, 16'd2);
    add(0, 1, 1, 0, 0, 16'd8, O_IDLE, 16'd2);
    add(0, 1, 0, 0, 0, 16'd8, O_ARM, 16'd2);
    add(0, 0, 1, 0, 0, 16'd0, O_IDLE, 16'd2);
    add(0, 1, 0, 0, 0, 16'd8, O_ARM, 16'd2);
    add(0, 0, 0, 1, 0, 16'd0, O_CAPT, 16'd0);
    for (int k = 1; k < 8; k++) add(0, 0, 0, 0, 1, 16'd0, O_CAP, 16'(k));
    add(0, 0, 0, 0, 1, 16'd0, O_DONE, 16'd8);
    add(0, 0, 0, 0, 0, 16'd0, O_IDLE, 16'd8);
    // 6: reset at sample_idx=5, arm ignored under reset
    add(0, 1, 0, 0, 0, 16'd10, O_ARM, 16'd8);
    add(0, 0, 0, 1, 0, 16'd0, O_CAPT, 16'd0);
    for (int k = 1; k < 6; k++) add(0, 0, 0, 0, 1, 16'd0, O_CAP, 16'(k));
    add(1, 1, 0, 0, 1, 16'd10, O_IDLE, 16'd0);
    add(1, 1, 0, 0, 0, 16'd10, O_IDLE, 16'd0);
    add(0, 0, 0, 0, 0, 16'd0, O_IDLE, 16'd0);
    add(0, 0, 0, 1, 0, 16'd0, O_IDLE, 16'd0);

    foreach (vecs[i]) begin
      logic [3:0] ao;
      @(negedge clk);
      rst0 = vecs[i].r; if0.arm = vecs[i].a; if0.abort = vecs[i].ab;
      if0.trig_pulse = vecs[i].t; if0.sample_stb = vecs[i].s;
      if0.post_samples = vecs[i].ps;
      @(posedge clk);
      #1;
      ao = {if0.armed, if0.capture_en, if0.trig_seen, if0.done};
      checks++;
      if (ao !== vecs[i].eo || if0.sample_idx !== vecs[i].ei) begin
        errors++;
        $display("FAIL vec%0d: got outs=%b idx=%0d, required outs=%b idx=%0d",
                 i, ao, if0.sample_idx, vecs[i].eo, vecs[i].ei);
      end
    end

    // 5: auto-rearm, N=2, three triggers, retrigger during capture ignored
    step1(1, 0, 0, 0, 0, 4'd0);  chk1("ar reset", O_IDLE, 4'd0);
    step1(0, 1, 0, 0, 0, 4'd2);  chk1("ar arm", O_ARM, 4'd0);
    for (int rep = 0; rep < 3; rep++) begin
      step1(0, 0, 0, 0, 0, 4'd0); chk1("ar wait", O_ARM, (rep == 0) ? 4'd0 : 4'd2);
      step1(0, 0, 0, 1, 0, 4'd0); chk1("ar trig", O_CAPT, 4'd0);
      step1(0, 0, 0, 1, 0, 4'd0); chk1("ar retrig", O_CAP, 4'd0);
      step1(0, 0, 0, 0, 1, 4'd0); chk1("ar stb1", O_CAP, 4'd1);
      step1(0, 0, 0, 0, 1, 4'd0); chk1("ar done", O_DONE, 4'd2);
      step1(0, 0, 0, 0, 0, 4'd0); chk1("ar rearm", O_ARM, 4'd2);
    end
    checks++;
    if (done_cnt != 3) begin
      errors++;
      $display("FAIL ar done count: got %0d, required 3", done_cnt);
    end

    // maximum length 2**4-1: index reaches 15 without wrapping
    step1(0, 0, 1, 0, 0, 4'd0);  chk1("max abort", O_IDLE, 4'd2);
    step1(0, 1, 0, 0, 0, 4'd15); chk1("max arm", O_ARM, 4'd2);
    step1(0, 0, 0, 1, 0, 4'd0);  chk1("max trig", O_CAPT, 4'd0);
    for (int k = 1; k < 15; k++) begin
      step1(0, 0, 0, 0, 1, 4'd0); chk1("max stb", O_CAP, 4'(k));
    end
    step1(0, 0, 0, 0, 1, 4'd0);  chk1("max done", O_DONE, 4'd15);
    step1(0, 0, 0, 0, 0, 4'd0);  chk1("max rearm", O_ARM, 4'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
